// File: rtl/fluxo_dados_param_pkg.sv
// Shared constants for the project's datapaths, plus the rule that builds the
// power-up memory image.
package fluxo_dados_param_pkg;

  localparam int DEF_WIDTH   = 4;
  localparam int DEF_ADDR_W  = 4;
  localparam int DEF_TIMEOUT = 5000;

  // Power-up word for address i: a single bit walking through the word.
  function automatic int unsigned onehot_word(input int unsigned i,
                                              input int unsigned w);
    return 32'd1 << (i % w);
  endfunction

endpackage

// File: rtl/fluxo_dados_param_contador.sv
// Modulo-M counter with clear priority over count. SATURATE selects whether
// the count holds at M-1 or wraps back to 0.
module contador_m #(
  parameter int M        = 16,
  parameter bit SATURATE = 1'b0,
  localparam int QW      = (M > 1) ? $clog2(M) : 1
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          zera,
  input  logic          conta,
  output logic [QW-1:0] Q,
  output logic          fim
);

  localparam logic [QW-1:0] MAX = QW'(M - 1);

  logic [QW-1:0] r_q;

  // Count register: reset/clear first, then increment with wrap or saturation.
  always_ff @(posedge clock) begin
    if (reset || zera) begin
      r_q <= '0;
    end else if (conta) begin
      if (r_q == MAX) begin
        r_q <= SATURATE ? MAX : '0;
      end else begin
        r_q <= r_q + 1'b1;
      end
    end
  end

  assign Q   = r_q;
  assign fim = (r_q == MAX);

endmodule

// File: rtl/fluxo_dados_param.sv
// Datapath: address and limit counters, switch register, small RAM with
// combinational read, key-press edge detector and a saturating timeout counter.
module fluxo_dados_param
  import fluxo_dados_param_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              zeraC,
  input  logic              contaC,
  input  logic              zeraL,
  input  logic              contaL,
  input  logic              zeraR,
  input  logic              registraR,
  input  logic              zeraT,
  input  logic              contaT,
  input  logic              escreveM,
  input  logic [WIDTH-1:0]  chaves,
  output logic              chavesIgualMemoria,
  output logic              fimC,
  output logic              fimL,
  output logic              enderecoIgualLimite,
  output logic              jogada,
  output logic              timeout,
  output logic [ADDR_W-1:0] db_contagem,
  output logic [ADDR_W-1:0] db_limite,
  output logic [WIDTH-1:0]  db_chaves,
  output logic [WIDTH-1:0]  db_memoria
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam int TW    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef logic [WIDTH-1:0] mem_t [DEPTH];

  function automatic mem_t f_mem_init();
    mem_t m;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      m[i] = WIDTH'(onehot_word(i, WIDTH));
    end
    return m;
  endfunction

  // Power-up image only; reset intentionally never touches the array.
  mem_t             r_mem = f_mem_init();
  logic [WIDTH-1:0] r_chaves;
  logic             r_s1;
  logic             r_s2;
  logic [TW-1:0]    w_unused_tmo_q;

  contador_m #(.M(DEPTH), .SATURATE(1'b0)) u_cont_endereco (
    .clock (clock),
    .reset (reset),
    .zera  (zeraC),
    .conta (contaC),
    .Q     (db_contagem),
    .fim   (fimC)
  );

  contador_m #(.M(DEPTH), .SATURATE(1'b0)) u_cont_limite (
    .clock (clock),
    .reset (reset),
    .zera  (zeraL),
    .conta (contaL),
    .Q     (db_limite),
    .fim   (fimL)
  );

  // Count value is only observable through the timeout decode.
  contador_m #(.M(TIMEOUT), .SATURATE(1'b1)) u_cont_timeout (
    .clock (clock),
    .reset (reset),
    .zera  (zeraT),
    .conta (contaT),
    .Q     (w_unused_tmo_q),
    .fim   (timeout)
  );

  // Switch register: clear wins over load.
  always_ff @(posedge clock) begin
    if (reset || zeraR) begin
      r_chaves <= '0;
    end else if (registraR) begin
      r_chaves <= chaves;
    end
  end

  // RAM write of the current (pre-update) register at the current address.
  always_ff @(posedge clock) begin
    if (!reset && escreveM) begin
      r_mem[db_contagem] <= r_chaves;
    end
  end

  // Two-flop press detector on "any switch down".
  always_ff @(posedge clock) begin
    if (reset) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
    end else begin
      r_s1 <= |chaves;
      r_s2 <= r_s1;
    end
  end

  assign db_chaves           = r_chaves;
  assign db_memoria          = r_mem[db_contagem];
  assign chavesIgualMemoria  = (r_chaves == db_memoria);
  assign enderecoIgualLimite = (db_contagem == db_limite);
  assign jogada              = r_s1 & ~r_s2;

endmodule
